registers_bram_ctrl: RTL



---
 rtl/registers_bram_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/registers_bram_ctrl.sv
// Access controller for the per-thread register file BRAM: arbitrates the single
// write port between CPU writeback and a buffered memory-load FIFO, and sequences reads.
module registers_bram_ctrl #(
  parameter int WIDTH      = 16,
  parameter int N_THREADS  = 6,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = 4,
  localparam int TW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 cpu_wr_req,
  input  logic [AW-1:0]        cpu_wr_addr,
  input  logic [TW-1:0]        cpu_wr_thread,
  input  logic [1:0]           cpu_wr_sel,
  input  logic                 mem_wr_req,
  output logic                 mem_wr_ready,
  input  logic [AW-1:0]        mem_wr_addr,
  input  logic [TW-1:0]        mem_wr_thread,
  input  logic [WIDTH-1:0]     mem_wr_data,
  input  logic                 rd_req,
  input  logic [AW-1:0]        rd_addr,
  input  logic [TW-1:0]        rd_thread,
  output logic                 rd_ready,
  output logic                 rd_valid,
  output logic [TW-1:0]        rd_thread_out,
  output logic [N_THREADS-1:0] thread_busy,
  output logic [1:0]           reg_din_select,
  output logic                 wr_en,
  output logic                 mem_wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [TW-1:0]        wr_thread_num,
  output logic [WIDTH-1:0]     mem_din_o,
  output logic [AW-1:0]        rd_addr_o,
  output logic [TW-1:0]        rd_thread_num,
  output logic                 rd_en0,
  output logic                 rd_en1
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [TW-1:0]         fifo_thread_q [FIFO_DEPTH];
  logic [AW-1:0]         fifo_addr_q   [FIFO_DEPTH];
  logic [WIDTH-1:0]      fifo_data_q   [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_DEPTH-1:0] valid_s;
  logic [N_THREADS-1:0]  busy_s;
  logic                  hazard_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q;
  logic [TW-1:0]         s1_thread_q, s2_thread_q;

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    valid_s = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      valid_s[i] = {1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q;
    end
  end

  // Busy map and read hazard, from registered FIFO contents plus the live CPU target.
  always_comb begin
    busy_s   = '0;
    hazard_s = cpu_wr_req & (cpu_wr_thread == rd_thread) & (cpu_wr_addr == rd_addr);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      hazard_s = hazard_s | (valid_s[i] & (fifo_thread_q[i] == rd_thread) &
                             (fifo_addr_q[i] == rd_addr));
      for (int t = 0; t < N_THREADS; t++) begin
        busy_s[t] = busy_s[t] | (valid_s[i] & (fifo_thread_q[i] == TW'(t)));
      end
    end
  end

  assign mem_wr_ready = rst_n & (count_q != CW'(FIFO_DEPTH));
  assign push_s       = mem_wr_req & mem_wr_ready;
  assign thread_busy  = rst_n ? busy_s : '0;
  assign mem_din_o    = fifo_data_q[rd_ptr_q];

  // Write-port arbitration: CPU always wins, otherwise drain the FIFO head.
  always_comb begin
    wr_en          = 1'b0;
    mem_wr_en      = 1'b0;
    pop_s          = 1'b0;
    reg_din_select = 2'd0;
    wr_addr        = cpu_wr_addr;
    wr_thread_num  = cpu_wr_thread;
    if (!rst_n) begin
      wr_en = 1'b0;
    end else if (cpu_wr_req) begin
      wr_en          = 1'b1;
      reg_din_select = (cpu_wr_sel == 2'd0) ? 2'd1 : cpu_wr_sel;
    end else if (count_q != CW'(0)) begin
      mem_wr_en     = 1'b1;
      pop_s         = 1'b1;
      wr_addr       = fifo_addr_q[rd_ptr_q];
      wr_thread_num = fifo_thread_q[rd_ptr_q];
    end else begin
      mem_wr_en = 1'b0;
    end
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign rd_ready      = rst_n & ~hazard_s;
  assign rd_en0        = rd_req & rd_ready;
  assign rd_addr_o     = rd_addr;
  assign rd_thread_num = rd_thread;
  assign s1_valid_d    = rd_en0;
  assign rd_en1        = rst_n & s1_valid_q;
  assign rd_valid      = rst_n & s2_valid_q;
  assign rd_thread_out = s2_thread_q;

  // Control state: FIFO pointers/count and the two read pipeline stages.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_thread_q <= '0;
      s2_thread_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s1_valid_q;
      s1_thread_q <= rd_thread;
      s2_thread_q <= s1_thread_q;
    end
  end

  // FIFO payload storage; contents only matter while covered by count_q.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      fifo_thread_q[wr_ptr_q] <= mem_wr_thread;
      fifo_addr_q[wr_ptr_q]   <= mem_wr_addr;
      fifo_data_q[wr_ptr_q]   <= mem_wr_data;
    end
  end

endmodule
